// File: rtl/dm_dma_if.sv
// dm_dma_if: data-memory bus between the DMA engine (master) and memory/peripherals (slave).
// Latency: none, bundle of wires only.
// Backpressure: bus_gnt from the slave side gates every strobe the master drives.
interface dm_dma_if;
    logic        bus_gnt;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_op;
    logic [31:0] rdata;

    modport master (
        input  bus_gnt,
        input  rdata,
        output dm_r,
        output dm_w,
        output addr,
        output wdata,
        output dm_op
    );

    modport slave (
        output bus_gnt,
        output rdata,
        input  dm_r,
        input  dm_w,
        input  addr,
        input  wdata,
        input  dm_op
    );
endinterface

// File: rtl/dm_dma.sv
// dm_dma: word-granular memory-to-memory copy engine on a shared data bus, optional fill mode.
// Latency: N-word copy pulses done 2N+1 cycles after start (fill: N+1) with bus_gnt held high.
// Backpressure: bus_gnt low freezes RD/WR with strobes low; start is ignored while busy.
// Optional feature macro: DM_DMA_FILL_EN (fill_mode/fill_data honoured only when defined).
module dm_dma #(
    parameter int unsigned LEN_W    = 10,
    parameter logic [2:0]  DM_OP_WD = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             fill_mode,
    input  logic [31:0]      fill_data,
    dm_dma_if.master         bus,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] xfer_cnt
);

`ifdef DM_DMA_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [31:0]      fdat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             fill_q;
    logic             start_fill;
    logic             last_wr;

    // Fill is only ever requested when the feature is compiled in.
    assign start_fill = FILL_EN & fill_mode;
    assign cnt_inc    = cnt_q + LEN_W'(1);
    assign last_wr    = (cnt_inc == len_q);
    assign xfer_cnt   = cnt_q;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: each bus phase advances only on a granted cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else if (start_fill) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.bus_gnt) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.bus_gnt) begin
                    if (last_wr) begin
                        state_d = S_FIN;
                    end else if (fill_q) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from state and registers only (start never reaches a strobe).
    always_comb begin
        bus.dm_r  = 1'b0;
        bus.dm_w  = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.dm_op = DM_OP_WD;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        case (state_q)
            S_RD: begin
                bus.dm_r = bus.bus_gnt;
                bus.addr = src_q;
            end
            S_WR: begin
                bus.dm_w  = bus.bus_gnt;
                bus.addr  = dst_q;
                bus.wdata = fill_q ? fdat_q : data_q;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: latch the request at start, then step pointers and count on granted cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= 32'h0;
            dst_q  <= 32'h0;
            data_q <= 32'h0;
            fdat_q <= 32'h0;
            len_q  <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Byte offsets are dropped: the engine only moves aligned words.
                        src_q  <= src_addr & ~32'h3;
                        dst_q  <= dst_addr & ~32'h3;
                        len_q  <= len;
                        fill_q <= start_fill;
                        fdat_q <= fill_data;
                        cnt_q  <= '0;
                    end
                end
                S_RD: begin
                    if (bus.bus_gnt) begin
                        data_q <= bus.rdata;
                        src_q  <= src_q + 32'd4;
                    end
                end
                S_WR: begin
                    if (bus.bus_gnt) begin
                        dst_q <= dst_q + 32'd4;
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_dma.sv
// tb_dm_dma: table-driven plus randomized checks of dm_dma against a word-level copy/fill model.
// Latency: n/a (testbench).
// Backpressure: bus_gnt patterns are generated per cycle from a table or $urandom.
module tb_dm_dma;

`ifdef DM_DMA_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif
    localparam logic [2:0] OP_WD = 3'b010;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [9:0]  len;
    logic        fill_mode;
    logic [31:0] fill_data;
    logic        gnt;
    logic        busy;
    logic        done;
    logic [9:0]  xfer_cnt;

    dm_dma_if bus ();

    dm_dma #(.LEN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_mode (fill_mode),
        .fill_data (fill_data),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side memory: 256 words, aliased on addr[9:2]; reads are combinational.
    logic [31:0] mem [0:255];
    logic        mem_ld;
    int          mem_seed;
    assign bus.bus_gnt = gnt;
    assign bus.rdata   = bus.dm_r ? mem[bus.addr[9:2]] : 32'h0;

    function automatic logic [31:0] mem_fn(input int seed, input int i);
        if (seed == 0) return 32'(i + 1) * 32'h11;
        return (32'(i) * 32'h9E37_79B1) ^ 32'(seed);
    endfunction

    int          n_wr, n_rd, n_done, n_busy, n_bad;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    // Memory commit and bus monitor, evaluated on the write-commit edge.
    always @(negedge clk) begin
        if (mem_ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_fn(mem_seed, i);
        end
        if (bus.dm_w) begin
            mem[bus.addr[9:2]] <= bus.wdata;
            wa_q.push_back(bus.addr);
            wd_q.push_back(bus.wdata);
            n_wr <= n_wr + 1;
        end
        if (bus.dm_r) n_rd <= n_rd + 1;
        if (bus.dm_r && bus.dm_w) n_bad <= n_bad + 1;
        if ((bus.dm_r || bus.dm_w) && !gnt) n_bad <= n_bad + 1;
        if (done) n_done <= n_done + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    initial begin
        n_wr = 0; n_rd = 0; n_done = 0; n_busy = 0; n_bad = 0;
    end

    int   n_chk;
    int   n_err;
    logic gnt_pat [0:511];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One transfer with the current gnt_pat; exp_lat_tbl < 0 means take latency from the model.
    task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic fm, input logic [31:0] fd, input int seed,
                            input int restart_at, input int exp_lat_tbl,
                            input logic chk_w0, input logic [31:0] exp_w0);
        logic [31:0] mm [0:255];
        logic [31:0] ea, ed, ra;
        int          w0, r0, d0, b0, q0, lat, exp_lat, k, g, need;
        logic        fill;
        @(posedge clk); #1;
        mem_seed = seed; mem_ld = 1'b1;
        @(posedge clk); #1;
        mem_ld = 1'b0;
        for (int i = 0; i < 256; i++) mm[i] = mem_fn(seed, i);
        w0 = n_wr; r0 = n_rd; d0 = n_done; b0 = n_busy; q0 = wa_q.size();
        start = 1'b1; src_addr = s; dst_addr = d; len = 10'(n);
        fill_mode = fm; fill_data = fd; gnt = gnt_pat[0];
        lat = -1;
        for (int c = 1; c < 400; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (c == restart_at) begin
                src_addr = s + 32'h100; dst_addr = d + 32'h40; len = 10'(n + 5);
            end
            gnt = gnt_pat[c];
            @(negedge clk);
            if (done && lat < 0) lat = c;
            if (lat >= 0 && c >= lat + 3) break;
        end
        @(posedge clk); #1;
        gnt = 1'b1;
        if (lat < 0) begin
            chk({tag, "/timeout"}, 64'd0, 64'd1);
            return;
        end
        fill = FILL_EN & fm;
        need = fill ? n : 2 * n;
        k = 1; g = 0;
        while (g < need) begin
            if (gnt_pat[k]) g++;
            k++;
        end
        exp_lat = (exp_lat_tbl >= 0) ? exp_lat_tbl : k;
        chk({tag, "/done_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/busy_cycles"}, 64'(n_busy - b0), 64'(exp_lat));
        chk({tag, "/done_pulses"}, 64'(n_done - d0), 64'd1);
        chk({tag, "/writes"}, 64'(n_wr - w0), 64'(n));
        chk({tag, "/reads"}, 64'(n_rd - r0), fill ? 64'd0 : 64'(n));
        chk({tag, "/xfer_cnt"}, 64'(xfer_cnt), 64'(n));
        for (int i = 0; i < n && (q0 + i) < wa_q.size(); i++) begin
            ea = (d & ~32'h3) + 32'(4 * i);
            if (fill) begin
                ed = fd;
            end else begin
                ra = (s & ~32'h3) + 32'(4 * i);
                ed = mm[ra[9:2]];
            end
            mm[ea[9:2]] = ed;
            chk($sformatf("%s/waddr%0d", tag, i), 64'(wa_q[q0 + i]), 64'(ea));
            chk($sformatf("%s/wdata%0d", tag, i), 64'(wd_q[q0 + i]), 64'(ed));
        end
        if (chk_w0 && q0 < wa_q.size()) chk({tag, "/first_word"}, 64'(wd_q[q0]), 64'(exp_w0));
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        int          n;
        logic        fm;
        logic [31:0] fd;
        int          stall_at;
        int          stall_n;
        int          restart_at;
        int          exp_lat;
        logic [31:0] exp_w0;
    } vec_t;

    vec_t tbl [7];
    int   w_s, d_s, b_s, r_s, q_s;

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len = '0;
        fill_mode = 1'b0; fill_data = 32'h0; gnt = 1'b1; mem_ld = 1'b0; mem_seed = 0;
        n_chk = 0; n_err = 0;

        // Reset state, with a start pulse that reset must override.
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; len = 10'd4;
        @(negedge clk);
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/dm_r", 64'(bus.dm_r), 64'd0);
        chk("rst/dm_w", 64'(bus.dm_w), 64'd0);
        chk("rst/xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst/addr", 64'(bus.addr), 64'd0);
        chk("rst/wdata", 64'(bus.wdata), 64'd0);
        chk("rst/dm_op", 64'(bus.dm_op), 64'(OP_WD));
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio/busy", 64'(busy), 64'd0);

        //           src            dst            n  fm    fill_data     stall  rst  lat  first word
        tbl[0] = '{32'h8000_0000, 32'h8003_0010, 4, 1'b0, 32'h0,         0, 0, 0,  9, 32'h11};
        tbl[1] = '{32'h8000_0000, 32'h8000_0040, 0, 1'b0, 32'h0,         0, 0, 0,  1, 32'h0};
        tbl[2] = '{32'h8000_0000, 32'h8000_0040, 2, 1'b0, 32'h0,         2, 3, 0,  8, 32'h11};
        tbl[3] = '{32'h8000_0000, 32'h8000_0080, 3, 1'b0, 32'h0,         0, 0, 3,  7, 32'h11};
        tbl[4] = '{32'h8000_0007, 32'h8000_0083, 1, 1'b0, 32'h0,         0, 0, 0,  3, 32'h22};
        tbl[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b0, 32'h0,         0, 0, 0,  7, 32'h10EF};
`ifdef DM_DMA_FILL_EN
        tbl[6] = '{32'h8000_0000, 32'h8000_0100, 3, 1'b1, 32'hDEADBEEF,  0, 0, 0,  4, 32'hDEADBEEF};
`else
        tbl[6] = '{32'h8000_0000, 32'h8000_0100, 3, 1'b1, 32'hDEADBEEF,  0, 0, 0,  7, 32'h11};
`endif
        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < 512; c++) begin
                gnt_pat[c] = !(tbl[v].stall_n > 0 && c >= tbl[v].stall_at &&
                               c < tbl[v].stall_at + tbl[v].stall_n);
            end
            run_xfer($sformatf("vec%0d", v), tbl[v].s, tbl[v].d, tbl[v].n, tbl[v].fm, tbl[v].fd,
                     0, tbl[v].restart_at, tbl[v].exp_lat, (tbl[v].n > 0), tbl[v].exp_w0);
        end

        // Reset during the second read of an 8-word copy: one word already committed, then silence.
        for (int c = 0; c < 512; c++) gnt_pat[c] = 1'b1;
        @(posedge clk); #1;
        mem_seed = 0; mem_ld = 1'b1;
        @(posedge clk); #1;
        mem_ld = 1'b0;
        w_s = n_wr; d_s = n_done; q_s = wa_q.size();
        start = 1'b1; src_addr = 32'h8000_0000; dst_addr = 32'h8000_0200; len = 10'd8; fill_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort/busy", 64'(busy), 64'd0);
        chk("abort/xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("abort/writes", 64'(n_wr - w_s), 64'd1);
        if (q_s < wa_q.size()) begin
            chk("abort/waddr", 64'(wa_q[q_s]), 64'h8000_0200);
            chk("abort/wdata", 64'(wd_q[q_s]), 64'h11);
        end
        w_s = n_wr; r_s = n_rd; b_s = n_busy;
        repeat (20) @(posedge clk);
        #1;
        chk("abort/later_writes", 64'(n_wr - w_s), 64'd0);
        chk("abort/later_reads", 64'(n_rd - r_s), 64'd0);
        chk("abort/later_busy", 64'(n_busy - b_s), 64'd0);
        chk("abort/done_pulses", 64'(n_done - d_s), 64'd0);

        // Randomized transfers with random grant gaps, addresses, lengths and modes.
        for (int t = 0; t < 20; t++) begin
            int          rn;
            logic [31:0] rs, rd, rfd;
            logic        rfm;
            rn  = $urandom_range(0, 12);
            rs  = $urandom;
            rd  = $urandom;
            rfd = $urandom;
            rfm = 1'($urandom_range(0, 1));
            for (int c = 0; c < 512; c++) gnt_pat[c] = ($urandom_range(0, 3) != 0);
            run_xfer($sformatf("rnd%0d", t), rs, rd, rn, rfm, rfd, int'($urandom) | 1,
                     (rn >= 2) ? 2 : 0, -1, 1'b0, 32'h0);
        end

        chk("bus/strobe_rules", 64'(n_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
